// File: rtl/ikaopll_reg_phase_rx.sv
// Deserialises the LSB-first Ch6/Carrier2 phase stream into a parallel word with a 1-cycle valid strobe.
// Word is valid 1 i_EMUCLK cycle after the last bit is sampled; the receiver never stalls the sender.
module ikaopll_reg_phase_rx #(
    parameter int PHASE_WIDTH = 19
) (
    input  logic                   i_EMUCLK,
    input  logic                   i_MRST,
    input  logic                   i_phi1_NCEN_n,
    input  logic                   i_SYNC,
    input  logic                   i_REG_PHASE_CH6_C2,
    output logic [PHASE_WIDTH-1:0] o_PHASE,
    output logic [9:0]             o_PHASEDATA_HI,
    output logic                   o_PHASE_VLD,
    output logic                   o_FRAME_ERR
);

    localparam int CW = $clog2(PHASE_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(PHASE_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [PHASE_WIDTH-2:0] r_sr;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic [9:0]             r_phase_hi;
    logic                   r_vld;
    logic                   r_err;

    // The final bit goes straight into the output word, so the shift register holds one bit less.
    logic [PHASE_WIDTH-1:0] w_word;
    assign w_word = {i_REG_PHASE_CH6_C2, r_sr};

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_phase    <= '0;
            r_phase_hi <= '0;
            r_vld      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (!i_phi1_NCEN_n) begin
                case (r_state)
                    IDLE: begin
                        if (i_SYNC) begin
                            r_sr[0] <= i_REG_PHASE_CH6_C2;
                            r_cnt   <= CW'(1);
                            r_state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (i_SYNC) begin
                            // Early sync: flag the truncated frame and restart on this bit.
                            r_err   <= 1'b1;
                            r_sr[0] <= i_REG_PHASE_CH6_C2;
                            r_cnt   <= CW'(1);
                        end else if (r_cnt == LAST_BIT) begin
                            r_phase    <= w_word;
                            r_phase_hi <= w_word[PHASE_WIDTH-1 -: 10];
                            r_vld      <= 1'b1;
                            r_err      <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= IDLE;
                        end else begin
                            r_sr[r_cnt] <= i_REG_PHASE_CH6_C2;
                            r_cnt       <= r_cnt + CW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_PHASE        = r_phase;
    assign o_PHASEDATA_HI = r_phase_hi;
    assign o_PHASE_VLD    = r_vld;
    assign o_FRAME_ERR    = r_err;

endmodule

// File: tb/tb_ikaopll_reg_phase_rx.sv
// Directed bench for ikaopll_reg_phase_rx; completed frames are checked against a scoreboard queue.
module tb_ikaopll_reg_phase_rx;

    logic        clk = 1'b0;
    logic        mrst = 1'b1;
    logic        ncen = 1'b1;
    logic        sync = 1'b0;
    logic        dat = 1'b0;
    logic [18:0] phase;
    logic [9:0]  phase_hi;
    logic        vld;
    logic        ferr;

    int n_chk  = 0;
    int n_pass = 0;
    int n_vld  = 0;
    int cyc    = 0;

    typedef struct {
        logic [18:0] w;
        int          c;
    } exp_t;
    exp_t q[$];

    ikaopll_reg_phase_rx #(.PHASE_WIDTH(19)) dut (
        .i_EMUCLK          (clk),
        .i_MRST            (mrst),
        .i_phi1_NCEN_n     (ncen),
        .i_SYNC            (sync),
        .i_REG_PHASE_CH6_C2(dat),
        .o_PHASE           (phase),
        .o_PHASEDATA_HI    (phase_hi),
        .o_PHASE_VLD       (vld),
        .o_FRAME_ERR       (ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Scoreboard side: every VLD must match the head entry in value and cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && cyc == q[0].c) begin
            chk("vld_time", {31'd0, vld}, 32'd1);
            if (vld === 1'b1) begin
                n_vld++;
                chk("sb_phase", {13'd0, phase}, {13'd0, q[0].w});
                chk("sb_phase_hi", {22'd0, phase_hi}, {22'd0, q[0].w[18:9]});
                chk("sb_err_clear", {31'd0, ferr}, 32'd0);
            end
            void'(q.pop_front());
        end else if (vld === 1'b1) begin
            n_vld++;
            chk("vld_unexpected", {31'd0, vld}, 32'd0);
        end
    end

    task automatic drive(input logic nc, input logic s, input logic d);
        @(posedge clk);
        #1;
        ncen = nc;
        sync = s;
        dat  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0);
    endtask

    // Sends bits lo..hi of w, one per enable, with gap disabled cycles of noise after each.
    task automatic send_bits(input logic [18:0] w, input int lo, input int hi,
                             input int gap, input bit sync_first);
        for (int i = lo; i <= hi; i++) begin
            drive(1'b0, (i == lo) && sync_first, w[i]);
            if (i == 18) q.push_back('{w, cyc + 1});
            repeat (gap) drive(1'b1, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", {13'd0, phase}, 32'd0);
        chk("rst_phase_hi", {22'd0, phase_hi}, 32'd0);
        chk("rst_vld", {31'd0, vld}, 32'd0);
        chk("rst_err", {31'd0, ferr}, 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        mrst = 1'b0;
        idle(2);

        // Single frame, enable every 4th cycle
        send_bits(19'h5A5A5, 0, 18, 3, 1'b1);
        idle(3);
        @(negedge clk);
        chk("t1_phase", {13'd0, phase}, 32'h5A5A5);
        chk("t1_hi", {22'd0, phase_hi}, 32'h2D2);
        chk("t1_vld_drop", {31'd0, vld}, 32'd0);

        // Back-to-back frames with no gap
        send_bits(19'h7FFFF, 0, 18, 0, 1'b1);
        send_bits(19'h00001, 0, 18, 0, 1'b1);
        idle(3);
        @(negedge clk);
        chk("t2_phase", {13'd0, phase}, 32'h00001);
        chk("t2_hi", {22'd0, phase_hi}, 32'h000);
        chk("t2_err", {31'd0, ferr}, 32'd0);

        // Short frame truncated by an early sync
        send_bits(19'h0AAAA, 0, 9, 1, 1'b1);
        send_bits(19'h12345, 0, 0, 1, 1'b1);
        @(negedge clk);
        chk("t3_err_set", {31'd0, ferr}, 32'd1);
        chk("t3_phase_held", {13'd0, phase}, 32'h00001);
        chk("t3_no_vld", {31'd0, vld}, 32'd0);
        send_bits(19'h12345, 1, 18, 1, 1'b0);
        idle(2);
        @(negedge clk);
        chk("t3_phase", {13'd0, phase}, 32'h12345);
        chk("t3_err_clr", {31'd0, ferr}, 32'd0);

        // Reset mid-frame overrides an enabled sync edge, then sync-less bits are ignored
        send_bits(19'h7FFFF, 0, 6, 1, 1'b1);
        @(posedge clk);
        #1;
        mrst = 1'b1;
        ncen = 1'b0;
        sync = 1'b1;
        dat  = 1'b1;
        @(posedge clk);
        #1;
        mrst = 1'b0;
        ncen = 1'b1;
        send_bits(19'h7FFFF, 0, 11, 1, 1'b0);
        idle(2);
        @(negedge clk);
        chk("t4_phase", {13'd0, phase}, 32'd0);
        chk("t4_hi", {22'd0, phase_hi}, 32'd0);
        chk("t4_err", {31'd0, ferr}, 32'd0);
        chk("t4_vld", {31'd0, vld}, 32'd0);

        // Long enable gap mid-frame with noisy inputs
        send_bits(19'h3C0F3, 0, 8, 1, 1'b1);
        repeat (50) drive(1'b1, 1'($urandom), 1'($urandom));
        @(negedge clk);
        chk("t5_phase_held", {13'd0, phase}, 32'd0);
        chk("t5_err_held", {31'd0, ferr}, 32'd0);
        send_bits(19'h3C0F3, 9, 18, 1, 1'b0);
        idle(2);
        @(negedge clk);
        chk("t5_phase", {13'd0, phase}, 32'h3C0F3);
        chk("t5_hi", {22'd0, phase_hi}, 32'h1E0);

        // Trailing garbage after a complete frame
        send_bits(19'h2B4D1, 0, 18, 1, 1'b1);
        send_bits(19'h7FFFF, 0, 4, 1, 1'b0);
        idle(4);
        @(negedge clk);
        chk("t6_phase", {13'd0, phase}, 32'h2B4D1);
        chk("t6_err", {31'd0, ferr}, 32'd0);

        chk("sb_pending", q.size(), 32'd0);
        chk("vld_count", n_vld, 32'd6);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
